// File: rtl/machine_seq_ctrl_pkg.sv
// machine_seq_ctrl_pkg
//   Shared constants for the machine_jk bring-up sequencer: default
//   pattern length, machine state width, and the sequencer FSM encoding.
//   No ports; imported by the interface and the sequencer.
package machine_seq_ctrl_pkg;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_S_W     = 3;

  typedef logic [1:0] state_t;

  // FSM encodings kept as plain constants so older tools can read them
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLR   = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/machine_seq_ctrl_if.sv
// machine_seq_ctrl_if
//   Bundle between the sequencer and the machine_jk datapath.
//   m_reset : machine reset pulse      (sequencer -> machine)
//   m_x     : machine input x          (sequencer -> machine)
//   m_f     : machine output F         (machine -> sequencer)
//   m_s     : machine state S[S_W-1:0] (machine -> sequencer)
//   master = sequencer side, slave = machine side.
interface machine_seq_ctrl_if
  import machine_seq_ctrl_pkg::*;
#(
  parameter int S_W = DEF_S_W
);

  logic           m_reset;
  logic           m_x;
  logic           m_f;
  logic [S_W-1:0] m_s;

  modport master (output m_reset, output m_x, input m_f, input m_s);
  modport slave  (input m_reset, input m_x, output m_f, output m_s);

endinterface

// File: rtl/machine_seq_ctrl.sv
// machine_seq_ctrl
//   Bring-up sequencer for machine_jk. Resets the machine, shifts a
//   programmed pattern into x (LSB first, one bit per clock), records F and
//   S after every bit, and can stop early when S reaches a target value.
// Ports
//   CLK, RESET       : clock, asynchronous active-high reset
//   start, abort     : run request (IDLE only) / immediate return to IDLE
//   len, pattern     : bit count (clamped to MAX_LEN) and bit pattern
//   stop_en, stop_s  : early-stop enable and target S
//   mbus (master)    : m_reset, m_x out; m_f, m_s in
//   busy, done, hit  : status; done is a one-cycle completion pulse
//   steps, f_count   : bits captured / F=1 captures in the last run
//   f_trace, s_final : per-bit captured F, last captured S
module machine_seq_ctrl
  import machine_seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = $clog2(MAX_LEN + 1),
  parameter int S_W     = DEF_S_W
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    len,
  input  logic [MAX_LEN-1:0]  pattern,
  input  logic                stop_en,
  input  logic [S_W-1:0]      stop_s,
  machine_seq_ctrl_if.master  mbus,
  output logic                busy,
  output logic                done,
  output logic                hit,
  output logic [CNT_W-1:0]    steps,
  output logic [CNT_W-1:0]    f_count,
  output logic [MAX_LEN-1:0]  f_trace,
  output logic [S_W-1:0]      s_final
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] shift_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   idx;
  logic               stop_en_q;
  logic [S_W-1:0]     stop_s_q;
  logic               x_vld;
  logic               f_vld;
  logic [CNT_W-1:0]   len_clamped;
  logic               stop_hit;

  // x_vld marks a pattern bit on m_x; f_vld follows one edge later, once
  // the machine has consumed that bit and its F/S are ready to capture.
  assign len_clamped  = (len > MAX_CNT) ? MAX_CNT : len;
  assign stop_hit     = f_vld && stop_en_q && (mbus.m_s == stop_s_q);
  assign busy         = (state != ST_IDLE);
  assign mbus.m_reset = (state == ST_CLR);

  // Sequencer FSM plus capture path. The capture runs alongside the FSM
  // because the last captures land while the FSM is already in DRAIN.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      shift_q   <= '0;
      len_q     <= '0;
      idx       <= '0;
      stop_en_q <= 1'b0;
      stop_s_q  <= '0;
      x_vld     <= 1'b0;
      f_vld     <= 1'b0;
      mbus.m_x  <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      steps     <= '0;
      f_count   <= '0;
      f_trace   <= '0;
      s_final   <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= ST_IDLE;
        mbus.m_x <= 1'b0;
        x_vld    <= 1'b0;
        f_vld    <= 1'b0;
      end else begin
        f_vld <= x_vld;
        if (f_vld) begin
          f_trace <= f_trace | (MAX_LEN'(mbus.m_f) << steps);
          s_final <= mbus.m_s;
          if (mbus.m_f && (f_count != MAX_CNT)) f_count <= f_count + 1'b1;
          if (steps != MAX_CNT) steps <= steps + 1'b1;
        end

        case (state)
          ST_IDLE: begin
            if (start) begin
              shift_q   <= pattern;
              len_q     <= len_clamped;
              stop_en_q <= stop_en;
              stop_s_q  <= stop_s;
              hit       <= 1'b0;
              steps     <= '0;
              f_count   <= '0;
              f_trace   <= '0;
              s_final   <= '0;
              state     <= ST_CLR;
            end
          end
          ST_CLR: begin
            if (len_q == '0) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              mbus.m_x <= shift_q[0];
              shift_q  <= shift_q >> 1;
              idx      <= CNT_W'(1);
              x_vld    <= 1'b1;
              state    <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (idx < len_q) begin
              mbus.m_x <= shift_q[0];
              shift_q  <= shift_q >> 1;
              idx      <= idx + 1'b1;
            end else begin
              mbus.m_x <= 1'b0;
              x_vld    <= 1'b0;
              state    <= ST_DRAIN;
            end
          end
          default: begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        endcase

        // Early stop overrides whatever the FSM chose this edge; a bit
        // already on m_x may have been consumed but is never captured.
        if (stop_hit) begin
          hit      <= 1'b1;
          done     <= 1'b1;
          state    <= ST_IDLE;
          mbus.m_x <= 1'b0;
          x_vld    <= 1'b0;
          f_vld    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_machine_seq_ctrl.sv
// tb_machine_seq_ctrl
//   Directed bench for machine_seq_ctrl driving a behavioural machine stub
//   (F <= x, S <= S + x, cleared by RESET or m_reset).
module tb_machine_seq_ctrl;

  logic        CLK;
  logic        RESET;
  logic        start;
  logic        abort;
  logic [4:0]  len;
  logic [15:0] pattern;
  logic        stop_en;
  logic [2:0]  stop_s;
  logic        busy;
  logic        done;
  logic        hit;
  logic [4:0]  steps;
  logic [4:0]  f_count;
  logic [15:0] f_trace;
  logic [2:0]  s_final;

  logic        mF;
  logic [2:0]  mS;

  int assertCount = 0;
  int failCount   = 0;

  int   cycles;
  logic mResetC1;
  logic mResetC2;
  logic busyC1;
  int   doneSeen;

  machine_seq_ctrl_if #(.S_W(3)) bus ();

  machine_seq_ctrl dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (start),
    .abort   (abort),
    .len     (len),
    .pattern (pattern),
    .stop_en (stop_en),
    .stop_s  (stop_s),
    .mbus    (bus.master),
    .busy    (busy),
    .done    (done),
    .hit     (hit),
    .steps   (steps),
    .f_count (f_count),
    .f_trace (f_trace),
    .s_final (s_final)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural machine stub
  always @(posedge CLK or posedge RESET) begin
    if (RESET || bus.m_reset) begin
      mF <= 1'b0;
      mS <= 3'd0;
    end else begin
      mF <= bus.m_x;
      mS <= mS + {2'b00, bus.m_x};
    end
  end

  assign bus.m_f = mF;
  assign bus.m_s = mS;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pulses start with the given setup, scrambles the inputs once they
  // should have been latched, and counts cycles (from the start cycle)
  // until done. repulse re-asserts start while the run is busy.
  task automatic applyStimulus(input logic [4:0] l, input logic [15:0] p,
                               input logic se, input logic [2:0] ss,
                               input logic repulse);
    @(posedge CLK); #1;
    len = l; pattern = p; stop_en = se; stop_s = ss; start = 1'b1;
    cycles = 0; mResetC1 = 1'b0; mResetC2 = 1'b0; busyC1 = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge CLK); #1;
      cycles++;
      if (cycles == 1) begin
        start = 1'b0;
        mResetC1 = bus.m_reset;
        busyC1 = busy;
        len = 5'd1; pattern = ~p; stop_en = ~se; stop_s = ss + 3'd3;
      end
      if (cycles == 2) mResetC2 = bus.m_reset;
      if (repulse && cycles == 3) start = 1'b1;
      if (repulse && cycles == 4) start = 1'b0;
      if (done) break;
    end
    if (!done) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      cycles = -1;
    end
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; abort = 1'b0; len = '0; pattern = '0;
    stop_en = 1'b0; stop_s = '0;
    #12;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_outputs", {done, hit, bus.m_reset, bus.m_x}, 0);
    checkOutput("rst_results", {steps, f_count, f_trace, s_final}, 0);
    RESET = 1'b0;

    // 1: plain run, pattern 1011 -> F 1,1,0,1 and S 1,2,2,3
    applyStimulus(5'd4, 16'h000B, 1'b0, 3'd0, 1'b0);
    checkOutput("t1_latency", cycles, 7);
    checkOutput("t1_mreset_on", mResetC1, 1);
    checkOutput("t1_mreset_off", mResetC2, 0);
    checkOutput("t1_busy", busyC1, 1);
    checkOutput("t1_trace", f_trace, 16'h000B);
    checkOutput("t1_fcount", f_count, 3);
    checkOutput("t1_sfinal", s_final, 3);
    checkOutput("t1_steps", steps, 4);
    checkOutput("t1_hit", hit, 0);
    @(posedge CLK); #1;
    checkOutput("t1_done_pulse", done, 0);
    checkOutput("t1_idle", busy, 0);

    // 2: early stop when S reaches 2 (captured at the 5th edge)
    applyStimulus(5'd4, 16'h000F, 1'b1, 3'd2, 1'b0);
    checkOutput("t2_latency", cycles, 5);
    checkOutput("t2_hit", hit, 1);
    checkOutput("t2_steps", steps, 2);
    checkOutput("t2_trace", f_trace, 16'h0003);
    checkOutput("t2_sfinal", s_final, 2);
    checkOutput("t2_mx", bus.m_x, 0);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("t2_hit_held", hit, 1);

    // 3: zero-length run still pulses m_reset, and clears hit
    applyStimulus(5'd0, 16'hFFFF, 1'b0, 3'd0, 1'b0);
    checkOutput("t3_latency", cycles, 2);
    checkOutput("t3_mreset_on", mResetC1, 1);
    checkOutput("t3_steps", steps, 0);
    checkOutput("t3_trace", f_trace, 0);
    checkOutput("t3_hit_cleared", hit, 0);

    // 6: len 20 clamps to 16; start re-pulsed while busy is ignored
    applyStimulus(5'd20, 16'hA5C7, 1'b0, 3'd0, 1'b1);
    checkOutput("t6_latency", cycles, 19);
    checkOutput("t6_steps", steps, 16);
    checkOutput("t6_trace", f_trace, 16'hA5C7);
    checkOutput("t6_fcount", f_count, 9);
    checkOutput("t6_sfinal", s_final, 1);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("t6_no_restart", busy, 0);

    // 4: abort after the first capture; results freeze, no done
    @(posedge CLK); #1;
    len = 5'd8; pattern = 16'h00FF; stop_en = 1'b0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_mx", bus.m_x, 0);
    checkOutput("t4_done", done, 0);
    checkOutput("t4_steps", steps, 1);
    checkOutput("t4_trace", f_trace, 16'h0001);
    doneSeen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge CLK); #1;
      if (done) doneSeen++;
    end
    checkOutput("t4_no_done", doneSeen, 0);
    checkOutput("t4_frozen", steps, 1);

    // abort wins over start in the same cycle
    start = 1'b1; abort = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; abort = 1'b0;
    checkOutput("abort_beats_start", busy, 0);

    // 5: asynchronous RESET between edges mid-run
    len = 5'd8; pattern = 16'h00FF; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    checkOutput("t5_running", busy, 1);
    #2 RESET = 1'b1;
    #1;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_outputs", {done, hit, bus.m_reset, bus.m_x}, 0);
    checkOutput("t5_results", {steps, f_count, f_trace, s_final}, 0);
    #2 RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("t5_stays_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
